// File: rtl/riscv_pkg.sv
// Shared types and helpers for the instruction prefetcher: fetch FSM states,
// RISC-V length decode and the halfword PC width.
package riscv_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_FETCH   = 2'd1,
      S_DISCARD = 2'd2
   } FetchState;

   function automatic logic isInsn32(input logic [15:0] halfword);
      return (halfword[1:0] == 2'b11);
   endfunction

   // A word-addressed bus of N lines needs N+1 bits to address halfwords.
   function automatic int halfwordPcWidth(input int addressSize);
      return addressSize + 1;
   endfunction

endpackage

// File: rtl/riscv_halfword_queue.sv
// Circular buffer of 16-bit halfwords with 0/1/2 push and pop per cycle,
// a flush that empties it, and a two-entry read port at the head.
module riscv_halfword_queue
   import riscv_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                         clock_i,
   input  logic                         reset_i,
   input  logic                         flush_i,
   input  logic [1:0]                   pushCount_i,
   input  logic [15:0]                  pushData0_i,
   input  logic [15:0]                  pushData1_i,
   input  logic [1:0]                   popCount_i,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic [15:0]                  head0_o,
   output logic [15:0]                  head1_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [15:0]      mem_q [DEPTH];
   logic [PTR_W-1:0] rdPtr_q;
   logic [PTR_W-1:0] rdPtr_d;
   logic [PTR_W-1:0] wrPtr_q;
   logic [PTR_W-1:0] wrPtr_d;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic [PTR_W-1:0] wrPtrPlus1;
   logic [PTR_W-1:0] rdPtrPlus1;

   assign wrPtrPlus1 = wrPtr_q + PTR_W'(1);
   assign rdPtrPlus1 = rdPtr_q + PTR_W'(1);

   // Pointer and occupancy next state; a flush overrides any push or pop.
   always_comb begin
      rdPtr_d = rdPtr_q;
      wrPtr_d = wrPtr_q;
      count_d = count_q;
      if (flush_i) begin
         rdPtr_d = {PTR_W{1'b0}};
         wrPtr_d = {PTR_W{1'b0}};
         count_d = {CNT_W{1'b0}};
      end else begin
         wrPtr_d = wrPtr_q + PTR_W'(pushCount_i);
         rdPtr_d = rdPtr_q + PTR_W'(popCount_i);
         count_d = count_q + CNT_W'(pushCount_i) - CNT_W'(popCount_i);
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         rdPtr_q <= {PTR_W{1'b0}};
         wrPtr_q <= {PTR_W{1'b0}};
         count_q <= {CNT_W{1'b0}};
      end else begin
         rdPtr_q <= rdPtr_d;
         wrPtr_q <= wrPtr_d;
         count_q <= count_d;
      end
   end

   // Halfword storage; contents beyond count are don't-care, so no reset.
   always_ff @(posedge clock_i) begin
      if (!flush_i && !reset_i) begin
         if (pushCount_i != 2'd0) begin
            mem_q[wrPtr_q] <= pushData0_i;
         end
         if (pushCount_i == 2'd2) begin
            mem_q[wrPtrPlus1] <= pushData1_i;
         end
      end
   end

   assign count_o = count_q;
   assign head0_o = mem_q[rdPtr_q];
   assign head1_o = mem_q[rdPtrPlus1];

endmodule

// File: rtl/riscv_insn_prefetcher.sv
// Instruction prefetch queue: fetches 32-bit words into a halfword queue and
// presents one assembled 16/32-bit instruction per cycle, with redirect/flush.
module riscv_insn_prefetcher
   import riscv_pkg::*;
#(
   parameter int          ADDRESS_SIZE     = 15,
   parameter int unsigned RESET_PC_ADDRESS = 32'h0000_1000,
   parameter int          QUEUE_DEPTH      = 8
) (
   input  logic                    clock,
   input  logic                    reset,
   output logic [ADDRESS_SIZE-1:0] memAddress,
   output logic                    memStrobe,
   input  logic                    memReady,
   input  logic [31:0]             memDataRead,
   input  logic                    redirect,
   input  logic [ADDRESS_SIZE:0]   redirectPc,
   output logic                    insnValid,
   output logic [31:0]             insnCode,
   output logic                    insnIs32,
   output logic [ADDRESS_SIZE:0]   insnPc,
   input  logic                    insnAccept
);

   localparam int PC_W  = halfwordPcWidth(ADDRESS_SIZE);
   localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
   localparam logic [PC_W-1:0]  RESET_PC = PC_W'(RESET_PC_ADDRESS >> 1);
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(QUEUE_DEPTH);

   FetchState              state_q;
   FetchState              state_d;
   logic [PC_W-1:0]        fetchPc_q;
   logic [PC_W-1:0]        fetchPc_d;
   logic [PC_W-1:0]        insnPc_q;
   logic [PC_W-1:0]        insnPc_d;
   logic [ADDRESS_SIZE-1:0] memAddress_q;
   logic [ADDRESS_SIZE-1:0] memAddress_d;
   logic                   memStrobe_q;
   logic                   memStrobe_d;

   logic [1:0]             pushCount;
   logic [15:0]            pushData0;
   logic [15:0]            pushData1;
   logic [1:0]             popCount;
   logic [CNT_W-1:0]       qCount;
   logic [15:0]            head0;
   logic [15:0]            head1;
   logic                   hasSpace;

   riscv_halfword_queue #(
      .DEPTH(QUEUE_DEPTH)
   ) u_queue (
      .clock_i     (clock),
      .reset_i     (reset),
      .flush_i     (redirect),
      .pushCount_i (pushCount),
      .pushData0_i (pushData0),
      .pushData1_i (pushData1),
      .popCount_i  (popCount),
      .count_o     (qCount),
      .head0_o     (head0),
      .head1_o     (head1)
   );

   assign hasSpace  = ((DEPTH_C - qCount) >= CNT_W'(2));
   assign insnIs32  = isInsn32(head0);
   assign insnValid = (qCount >= CNT_W'(2)) || ((qCount != {CNT_W{1'b0}}) && !insnIs32);
   assign insnCode  = insnIs32 ? {head1, head0} : {16'h0000, head0};

   // Fetch FSM next state, enqueue control and fetch PC tracking.
   always_comb begin
      state_d      = state_q;
      fetchPc_d    = fetchPc_q;
      memAddress_d = memAddress_q;
      memStrobe_d  = memStrobe_q;
      pushCount    = 2'd0;
      pushData0    = 16'h0000;
      pushData1    = 16'h0000;
      case (state_q)
         S_IDLE: begin
            if (!redirect && hasSpace) begin
               memAddress_d = fetchPc_q[ADDRESS_SIZE:1];
               memStrobe_d  = 1'b1;
               state_d      = S_FETCH;
            end else begin
               state_d      = S_IDLE;
            end
         end
         S_FETCH: begin
            // Ready coinciding with a redirect completes the bus cycle, so
            // the stale word is simply dropped instead of waiting in discard.
            if (memReady) begin
               memStrobe_d = 1'b0;
               state_d     = S_IDLE;
               if (redirect) begin
                  pushCount = 2'd0;
               end else if (fetchPc_q[0]) begin
                  pushCount = 2'd1;
                  pushData0 = memDataRead[31:16];
                  fetchPc_d = fetchPc_q + PC_W'(1);
               end else begin
                  pushCount = 2'd2;
                  pushData0 = memDataRead[15:0];
                  pushData1 = memDataRead[31:16];
                  fetchPc_d = fetchPc_q + PC_W'(2);
               end
            end else if (redirect) begin
               state_d = S_DISCARD;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_DISCARD: begin
            if (memReady) begin
               memStrobe_d = 1'b0;
               state_d     = S_IDLE;
            end else begin
               state_d     = S_DISCARD;
            end
         end
         default: begin
            memStrobe_d = 1'b0;
            state_d     = S_IDLE;
         end
      endcase
      if (redirect) begin
         fetchPc_d = redirectPc;
      end else begin
         fetchPc_d = fetchPc_d;
      end
   end

   // Consumer side: pop the head and advance the instruction PC.
   always_comb begin
      popCount = 2'd0;
      insnPc_d = insnPc_q;
      if (insnValid && insnAccept) begin
         popCount = insnIs32 ? 2'd2 : 2'd1;
      end else begin
         popCount = 2'd0;
      end
      if (redirect) begin
         insnPc_d = redirectPc;
      end else begin
         insnPc_d = insnPc_q + PC_W'(popCount);
      end
   end

   // State and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_IDLE;
         fetchPc_q    <= RESET_PC;
         insnPc_q     <= RESET_PC;
         memAddress_q <= {ADDRESS_SIZE{1'b0}};
         memStrobe_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         fetchPc_q    <= fetchPc_d;
         insnPc_q     <= insnPc_d;
         memAddress_q <= memAddress_d;
         memStrobe_q  <= memStrobe_d;
      end
   end

   assign memAddress = memAddress_q;
   assign memStrobe  = memStrobe_q;
   assign insnPc     = insnPc_q;

endmodule

// File: tb/tb_riscv_insn_prefetcher.sv
// Scoreboard bench for riscv_insn_prefetcher: directed memory images, expected
// instructions and fetch addresses queued up front, checked by a monitor.
module tb_riscv_insn_prefetcher;

   localparam int AS = 15;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [AS-1:0] memAddress;
   logic          memStrobe;
   logic          memReady = 1'b0;
   logic [31:0]   memDataRead = 32'h0;
   logic          redirect = 1'b0;
   logic [AS:0]   redirectPc = '0;
   logic          insnValid;
   logic [31:0]   insnCode;
   logic          insnIs32;
   logic [AS:0]   insnPc;
   logic          insnAccept = 1'b0;

   typedef struct packed {
      logic [31:0] code;
      logic [15:0] pc;
      logic        is32;
   } insn_t;

   insn_t         expInsn[$];
   logic [AS-1:0] expAddr[$];
   logic [31:0]   memArr[int];
   int nTests = 0;
   int nFail = 0;
   int readyDelay = 0;
   int waitCnt = 0;
   int strobeRises = 0;
   logic prevStrobe = 1'b0;

   always #5 clock = ~clock;

   riscv_insn_prefetcher #(
      .ADDRESS_SIZE(AS),
      .RESET_PC_ADDRESS(32'h1000),
      .QUEUE_DEPTH(8)
   ) dut (
      .clock(clock), .reset(reset),
      .memAddress(memAddress), .memStrobe(memStrobe),
      .memReady(memReady), .memDataRead(memDataRead),
      .redirect(redirect), .redirectPc(redirectPc),
      .insnValid(insnValid), .insnCode(insnCode), .insnIs32(insnIs32),
      .insnPc(insnPc), .insnAccept(insnAccept)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic failNow(input string name, input int got);
      nTests++;
      nFail++;
      $display("FAIL %s: got %0d outstanding, expected 0", name, got);
   endtask

   task automatic pushInsn(input logic [31:0] code, input logic [15:0] pc, input logic is32);
      insn_t e;
      e.code = code;
      e.pc = pc;
      e.is32 = is32;
      expInsn.push_back(e);
   endtask

   // Memory: answers a strobe after readyDelay idle cycles with a one-cycle ready.
   initial begin
      forever begin
         @(posedge clock); #1;
         if (reset) begin
            memReady = 1'b0;
            waitCnt = 0;
         end else if (memReady) begin
            memReady = 1'b0;
            waitCnt = 0;
         end else if (memStrobe) begin
            if (waitCnt >= readyDelay) begin
               memReady = 1'b1;
               memDataRead = memArr.exists(int'(memAddress)) ? memArr[int'(memAddress)] : 32'h0;
            end else begin
               waitCnt++;
            end
         end
      end
   end

   // Monitor: checks each new fetch address and each accepted instruction.
   initial begin
      insn_t e;
      logic [AS-1:0] a;
      forever begin
         @(negedge clock);
         if (reset) begin
            prevStrobe = 1'b0;
         end else begin
            if (memStrobe && !prevStrobe) begin
               strobeRises++;
               if (expAddr.size() > 0) begin
                  a = expAddr.pop_front();
                  check("fetch_addr", 32'(memAddress), 32'(a));
               end
            end
            prevStrobe = memStrobe;
            if (insnValid && insnAccept) begin
               if (expInsn.size() > 0) begin
                  e = expInsn.pop_front();
                  check("insn_code", insnCode, e.code);
                  check("insn_pc", 32'(insnPc), 32'(e.pc));
                  check("insn_is32", 32'(insnIs32), 32'(e.is32));
               end else begin
                  nTests++;
                  nFail++;
                  $display("FAIL unexpected_insn: got code %h pc %h, expected none", insnCode, insnPc);
               end
            end
         end
      end
   end

   // Applies reset for one edge, checks the reset state, and clears the scoreboard.
   task automatic doReset();
      @(posedge clock); #1;
      reset = 1'b1;
      insnAccept = 1'b0;
      redirect = 1'b0;
      @(posedge clock);
      @(negedge clock);
      check("rst_strobe", 32'(memStrobe), 32'h0);
      check("rst_addr", 32'(memAddress), 32'h0);
      check("rst_valid", 32'(insnValid), 32'h0);
      check("rst_pc", 32'(insnPc), 32'h800);
      repeat (2) @(posedge clock);
      #1;
      memArr.delete();
      expInsn.delete();
      expAddr.delete();
      strobeRises = 0;
   endtask

   task automatic drain(input string name);
      int cyc = 0;
      insnAccept = 1'b1;
      while (expInsn.size() > 0 && cyc < 300) begin
         @(posedge clock); #1;
         cyc++;
      end
      insnAccept = 1'b0;
      if (expInsn.size() > 0) begin
         failNow({name, "_insn_timeout"}, expInsn.size());
         expInsn.delete();
      end
      if (expAddr.size() > 0) begin
         failNow({name, "_addr_timeout"}, expAddr.size());
         expAddr.delete();
      end
   endtask

   task automatic waitStrobe(input string name);
      int cyc = 0;
      do begin
         @(negedge clock);
         cyc++;
      end while (!memStrobe && cyc < 50);
      if (!memStrobe) failNow({name, "_strobe_timeout"}, 1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      // 1: single 32-bit instruction after reset
      doReset();
      readyDelay = 0;
      memArr[32'h400] = 32'h0000_0013;
      expAddr.push_back(15'h400);
      pushInsn(32'h0000_0013, 16'h0800, 1'b1);
      reset = 1'b0;
      drain("t1");

      // 2: two 16-bit then one 32-bit
      doReset();
      memArr[32'h400] = 32'h4501_0505;
      memArr[32'h401] = 32'h0000_0013;
      expAddr.push_back(15'h400);
      expAddr.push_back(15'h401);
      pushInsn(32'h0000_0505, 16'h0800, 1'b0);
      pushInsn(32'h0000_4501, 16'h0801, 1'b0);
      pushInsn(32'h0000_0013, 16'h0802, 1'b1);
      reset = 1'b0;
      drain("t2");

      // 3: 32-bit instruction straddling two words
      doReset();
      readyDelay = 3;
      memArr[32'h400] = 32'h0513_0001;
      memArr[32'h401] = 32'h0001_0000;
      expAddr.push_back(15'h400);
      expAddr.push_back(15'h401);
      pushInsn(32'h0000_0001, 16'h0800, 1'b0);
      pushInsn(32'h0000_0513, 16'h0801, 1'b1);
      reset = 1'b0;
      insnAccept = 1'b1;
      cyc = 0;
      do begin
         @(negedge clock);
         cyc++;
      end while (!(memStrobe && memAddress == 15'h401) && cyc < 100);
      check("straddle_wait_valid", 32'(insnValid), 32'h0);
      drain("t3");

      // 4: redirect while a fetch is in flight
      doReset();
      readyDelay = 4;
      memArr[32'h400] = 32'hBEEF_BEEF;
      memArr[32'h401] = 32'h4505_1111;
      memArr[32'h402] = 32'h0000_0013;
      expAddr.push_back(15'h400);
      expAddr.push_back(15'h401);
      expAddr.push_back(15'h402);
      pushInsn(32'h0000_4505, 16'h0803, 1'b0);
      pushInsn(32'h0000_0013, 16'h0804, 1'b1);
      reset = 1'b0;
      waitStrobe("t4");
      @(posedge clock); #1;
      redirect = 1'b1;
      redirectPc = 16'h0803;
      @(posedge clock); #1;
      redirect = 1'b0;
      @(negedge clock);
      check("redir_valid", 32'(insnValid), 32'h0);
      check("redir_pc", 32'(insnPc), 32'h803);
      check("discard_strobe_held", 32'(memStrobe), 32'h1);
      drain("t4");

      // 5: queue fills with accept held low, then refills only with 2 free
      doReset();
      readyDelay = 0;
      for (int i = 0; i < 4; i++) memArr[32'h400 + i] = 32'h0005_0001;
      for (int i = 0; i < 5; i++) expAddr.push_back(15'(15'h400 + i));
      reset = 1'b0;
      repeat (60) @(negedge clock);
      check("full_fetches", 32'(strobeRises), 32'd4);
      check("full_strobe", 32'(memStrobe), 32'h0);
      pushInsn(32'h0000_0001, 16'h0800, 1'b0);
      @(posedge clock); #1; insnAccept = 1'b1;
      @(posedge clock); #1; insnAccept = 1'b0;
      repeat (20) @(negedge clock);
      check("one_free_no_fetch", 32'(strobeRises), 32'd4);
      pushInsn(32'h0000_0005, 16'h0801, 1'b0);
      @(posedge clock); #1; insnAccept = 1'b1;
      @(posedge clock); #1; insnAccept = 1'b0;
      cyc = 0;
      while (strobeRises < 5 && cyc < 10) begin
         @(negedge clock);
         cyc++;
      end
      check("two_free_fetch", 32'(strobeRises), 32'd5);
      drain("t5");

      // 6: fetch PC wraps from 0xFFFF to word 0
      doReset();
      memArr[32'h7FFF] = 32'h0009_0000;
      memArr[32'h0000] = 32'h0011_0001;
      expAddr.push_back(15'h7FFF);
      expAddr.push_back(15'h0000);
      pushInsn(32'h0000_0009, 16'hFFFF, 1'b0);
      pushInsn(32'h0000_0001, 16'h0000, 1'b0);
      pushInsn(32'h0000_0011, 16'h0001, 1'b0);
      reset = 1'b0;
      redirect = 1'b1;
      redirectPc = 16'hFFFF;
      @(posedge clock); #1;
      redirect = 1'b0;
      drain("t6");

      // 7: reset in the middle of a slow fetch drops the strobe
      readyDelay = 50;
      doReset();
      reset = 1'b0;
      waitStrobe("t7");
      doReset();

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
